// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - CPU-side character FIFO that drains into a UART transmitter register
//
// Purpose: buffers characters pushed by the CPU and hands them one at a time
// to a UART transmitter, waiting for each frame to start and finish before
// issuing the next write.
//
// Optional feature macro: UART_TX_FIFO_OVF_CNT_EN adds the ovf_count output.
//
// Ports:
//   clock          - single clock, rising edge
//   reset          - asynchronous active-low reset
//   wr_en          - CPU push strobe
//   wr_data        - character to push (DATA_W bits)
//   full           - FIFO holds DEPTH entries (combinational from count)
//   count          - current occupancy
//   tx_busy        - UART transmitter shifting a frame
//   uart_wr_enable - one-cycle write strobe into the UART
//   uart_sel       - UART select, mirrors uart_wr_enable
//   uart_addr      - UART register address (1 during a write, else 0)
//   wdata_mem      - UART write data, zero-extended character
//   ovf_count      - dropped pushes, saturating at 255 (macro builds only)

module uart_tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     tx_busy,
  output logic                     uart_wr_enable,
  output logic                     uart_sel,
  output logic [3:0]               uart_addr,
  output logic [31:0]              wdata_mem
`ifdef UART_TX_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  // full is judged on the pre-edge occupancy, so a same-cycle pop never
  // makes room for a push.
  assign full = (count == CW'(DEPTH));
  assign push = wr_en && !full;
  assign pop  = (state == ISSUE);

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Drain FSM. The UART outputs default to zero every cycle and are only
  // loaded while in ISSUE, giving a single-cycle registered strobe that
  // appears two edges after the push that filled an empty FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      uart_wr_enable <= 1'b0;
      uart_sel       <= 1'b0;
      uart_addr      <= 4'h0;
      wdata_mem      <= 32'h0;
    end else begin
      uart_wr_enable <= 1'b0;
      uart_sel       <= 1'b0;
      uart_addr      <= 4'h0;
      wdata_mem      <= 32'h0;
      case (state)
        IDLE: begin
          if ((count != '0) && !tx_busy) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          uart_wr_enable <= 1'b1;
          uart_sel       <= 1'b1;
          uart_addr      <= 4'h1;
          wdata_mem      <= 32'(mem[rd_ptr]);
          state          <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_count <= 8'h00;
    end else if (wr_en && full && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a queue-based reference model

module tb_uart_tx_fifo;

  localparam int DEPTH = 8;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic [3:0]  count;
  logic        tx_busy;
  logic        uart_wr_enable;
  logic        uart_sel;
  logic [3:0]  uart_addr;
  logic [31:0] wdata_mem;
`ifdef UART_TX_FIFO_OVF_CNT_EN
  logic [7:0]  ovf_count;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .full           (full),
    .count          (count),
    .tx_busy        (tx_busy),
    .uart_wr_enable (uart_wr_enable),
    .uart_sel       (uart_sel),
    .uart_addr      (uart_addr),
    .wdata_mem      (wdata_mem)
`ifdef UART_TX_FIFO_OVF_CNT_EN
    ,
    .ovf_count      (ovf_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: a character queue in push order, an occupancy figure,
  // a saturating drop counter, and a simple UART that stays busy busy_len
  // cycles after each strobe it sees.
  logic [7:0] expq[$];
  int         model_cnt  = 0;
  int         ovf_model  = 0;
  int         strobes    = 0;
  int         busy_timer = 0;
  int         busy_len   = 5;
  bit         auto_busy  = 0;
  bit         prev_stb   = 0;

  typedef struct {
    logic       we;
    logic [7:0] d;
    int         exp_cnt;
    logic       exp_full;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic tick();
    logic       w;
    logic [7:0] d;
    logic       push_ok;
    w       = wr_en;
    d       = wr_data;
    push_ok = w && (model_cnt < DEPTH);
    @(posedge clock);
    #1;
    if (uart_wr_enable === 1'b1) begin
      strobes++;
      check("strobe_while_busy", 32'(tx_busy), 32'h0);
      check("strobe_one_cycle", 32'(prev_stb), 32'h0);
      check("strobe_sel", 32'(uart_sel), 32'h1);
      check("strobe_addr", 32'(uart_addr), 32'h1);
      if (expq.size() == 0) begin
        fail_now("strobe_unexpected");
      end else begin
        check("strobe_data", wdata_mem, {24'h0, expq.pop_front()});
        model_cnt--;
      end
      if (auto_busy) busy_timer = busy_len;
    end else begin
      check("quiet_outputs", {27'h0, uart_sel, uart_addr}, 32'h0);
      check("quiet_wdata", wdata_mem, 32'h0);
    end
    prev_stb = (uart_wr_enable === 1'b1);
    if (push_ok) begin
      expq.push_back(d);
      model_cnt++;
    end else if (w && ovf_model < 255) begin
      ovf_model++;
    end
    check("count", 32'(count), 32'(model_cnt));
    check("full", 32'(full), 32'(model_cnt == DEPTH));
`ifdef UART_TX_FIFO_OVF_CNT_EN
    check("ovf_count", 32'(ovf_count), 32'(ovf_model));
`endif
    if (auto_busy) begin
      tx_busy = (busy_timer > 0);
      if (busy_timer > 0) busy_timer--;
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((model_cnt != 0 || busy_timer != 0 || tx_busy) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) fail_now("drain_timeout");
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_busy = 1'b0;

    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{we: 1'b1, d: 8'(8'h10 + i), exp_cnt: i + 1, exp_full: (i == 7)};
    end
    tbl[8] = '{we: 1'b1, d: 8'h18, exp_cnt: 8, exp_full: 1'b1};
    tbl[9] = '{we: 1'b0, d: 8'h00, exp_cnt: 8, exp_full: 1'b1};

    // Reset state
    #12;
    check("rst_count", 32'(count), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_wr_enable", 32'(uart_wr_enable), 32'h0);
    check("rst_wdata", wdata_mem, 32'h0);
    check("rst_addr_sel", {27'h0, uart_sel, uart_addr}, 32'h0);
`ifdef UART_TX_FIFO_OVF_CNT_EN
    check("rst_ovf", 32'(ovf_count), 32'h0);
`endif
    reset = 1'b1;

    // Single push 0x41: strobe exactly at edge+2, one cycle long
    auto_busy = 1;
    busy_len  = 5;
    wr_en     = 1'b1;
    wr_data   = 8'h41;
    tick();
    wr_en = 1'b0;
    tick();
    check("single_no_early_strobe", 32'(uart_wr_enable), 32'h0);
    tick();
    check("single_strobe", 32'(uart_wr_enable), 32'h1);
    check("single_wdata", wdata_mem, 32'h00000041);
    check("single_addr", 32'(uart_addr), 32'h1);
    check("single_count", 32'(count), 32'h0);
    tick();
    check("single_strobe_end", 32'(uart_wr_enable), 32'h0);
    drain(200);

    // Table: fill with transmitter busy, ninth push dropped
    auto_busy = 0;
    tx_busy   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_en   = tbl[i].we;
      wr_data = tbl[i].d;
      tick();
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].exp_full));
    end
    wr_en = 1'b0;
`ifdef UART_TX_FIFO_OVF_CNT_EN
    check("tbl_ovf_one", 32'(ovf_count), 32'h1);
`endif

    // Pop and push in the same cycle while full: push dropped
    tx_busy   = 1'b0;
    auto_busy = 1;
    busy_len  = 3;
    tick();
    wr_en   = 1'b1;
    wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    check("full_pop_push_count", 32'(count), 32'h7);
    drain(500);

    // Same stimulus at count=4: count unchanged
    auto_busy = 0;
    tx_busy   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h20 + i);
      tick();
    end
    wr_en     = 1'b0;
    tx_busy   = 1'b0;
    auto_busy = 1;
    tick();
    wr_en   = 1'b1;
    wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    check("mid_pop_push_count", 32'(count), 32'h4);
    drain(500);

    // Long busy frames: three characters, three strobes
    busy_len = 20;
    s0       = strobes;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h31 + i);
      tick();
    end
    wr_en = 1'b0;
    drain(400);
    check("busy20_strobe_count", 32'(strobes - s0), 32'h3);

    // Overflow saturation
    auto_busy = 0;
    tx_busy   = 1'b1;
    wr_en     = 1'b1;
    for (int i = 0; i < 308; i++) begin
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    check("ovf_full_count", 32'(count), 32'h8);
`ifdef UART_TX_FIFO_OVF_CNT_EN
    check("ovf_saturated", 32'(ovf_count), 32'hFF);
`endif
    tx_busy   = 1'b0;
    auto_busy = 1;
    busy_len  = 2;
    drain(500);

    // Reset while a strobe is pending with entries queued
    auto_busy = 0;
    tx_busy   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h50 + i);
      tick();
    end
    wr_en     = 1'b0;
    tx_busy   = 1'b0;
    auto_busy = 1;
    tick();
    tick();
    check("rst_mid_strobe_seen", 32'(uart_wr_enable), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_wr_enable", 32'(uart_wr_enable), 32'h0);
    check("rst_mid_sel", 32'(uart_sel), 32'h0);
    check("rst_mid_wdata", wdata_mem, 32'h0);
    check("rst_mid_count", 32'(count), 32'h0);
    check("rst_mid_full", 32'(full), 32'h0);
`ifdef UART_TX_FIFO_OVF_CNT_EN
    check("rst_mid_ovf", 32'(ovf_count), 32'h0);
`endif
    expq.delete();
    model_cnt  = 0;
    ovf_model  = 0;
    busy_timer = 0;
    prev_stb   = 0;
    tx_busy    = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    s0    = strobes;
    repeat (30) tick();
    check("rst_no_strobes", 32'(strobes - s0), 32'h0);

    // Randomized traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      wr_en    = ($urandom_range(0, 9) < 4);
      wr_data  = 8'($urandom);
      busy_len = $urandom_range(1, 12);
      tick();
    end
    wr_en = 1'b0;
    drain(3000);
    check("final_count", 32'(count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
